// File: rtl/gauss_pkg.sv
// Shared definitions for the 3x3 Gaussian blur stream: FSM state codes,
// kernel weights, accumulator growth and a coordinate clamp helper.
package gauss_pkg;

  // FSM state codes
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRIME = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] EOL   = 3'd3;
  localparam logic [2:0] FLUSH = 3'd4;

  // Kernel weights sum to 16, so the accumulator grows by 4 bits
  // (SUM_W = DW + KERNEL_SHIFT) and the result is the sum shifted right by 4.
  localparam int KERNEL_SHIFT = 4;
  localparam int ROUND_HALF   = 1 << (KERNEL_SHIFT - 1);

  // Kernel [1 2 1; 2 4 2; 1 2 1], indexed by window column and row (0..2)
  function automatic int unsigned kernel_weight(input int col, input int row);
    return ((col == 1) ? 2 : 1) * ((row == 1) ? 2 : 1);
  endfunction

  // Clamp an index into 0..hi (edge replication at image borders)
  function automatic int clamp_idx(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/gauss_line_buffer.sv
// One image line of delay: the word read at addr is the one written at the
// same addr one line earlier. One read and one write per cycle, same address.
module gauss_line_buffer
  import gauss_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Old contents are read before the write at the same address lands
  assign dout = mem[addr];

  // Store the incoming word when the line advances
  // NOTE: the storage array has no reset; every location is written during
  // row 0 of a frame before it is ever read, and a reset branch would prevent
  // RAM inference. Non-blocking assignment keeps the read-before-write order.
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

endmodule

// File: rtl/gaussian_blur_3x3_stream.sv
// 3x3 Gaussian blur ([1 2 1;2 4 2;1 2 1]/16) on a raster pixel stream with
// valid/ready on both sides and edge replication at every border.
// Optional build macro: GAUSS_ROUND_EN selects round-half-up instead of
// truncation of the weighted sum.
module gaussian_blur_3x3_stream
  import gauss_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CH    = 3,
  parameter int DW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*DW-1:0] in_pixel,
  input  logic            in_sof,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*DW-1:0] out_pixel,
  output logic            out_sof,
  output logic            out_eol
);

  localparam int PW    = CH * DW;
  localparam int SUM_W = DW + KERNEL_SHIFT;
  localparam int XW    = $clog2(IMG_W + 1);
  localparam int YW    = $clog2(IMG_H);
  localparam int AW    = $clog2(IMG_W);

  logic [2:0]            state;
  logic [XW-1:0]         x_cnt;
  logic [YW-1:0]         y_cnt;
  logic                  out_free, in_acc, sof_restart, lb_shift;
  logic                  step_en, emit, edge_step;
  logic                  x_last, x_end, y_last;
  logic [AW-1:0]         lb_addr;
  logic [PW-1:0]         lb1_q, lb2_q;
  // Columns indexed by row: [0] top, [1] middle, [2] bottom
  logic [2:0][PW-1:0]    prev1, prev2, new_col, col_l, col_r;
  logic [2:0][2:0][PW-1:0] win;
  logic [CH-1:0][SUM_W-1:0] sums;
  logic [PW-1:0]         result;

  assign out_free    = !out_valid || out_ready;
  assign in_acc      = in_valid && in_ready;
  assign sof_restart = in_acc && in_sof && (state == PRIME || state == RUN);
  assign x_last      = (x_cnt == XW'(IMG_W - 1));
  assign x_end       = (x_cnt == XW'(IMG_W));
  assign y_last      = (y_cnt == YW'(IMG_H - 1));

  // Input acceptance: only in pixel-consuming states and only if the output slot can take a result
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    in_ready = 1'b0;
    if (!rst && (state == IDLE || state == PRIME || state == RUN)) in_ready = out_free;
  end

  // Window stepping and output emission decisions for the current cycle
  always_comb begin
    step_en   = 1'b0;
    emit      = 1'b0;
    edge_step = 1'b0;
    case (state)
      RUN: begin
        if (in_acc && !in_sof) begin
          step_en = 1'b1;
          emit    = (x_cnt != '0);      // column 0 only loads the window
        end
      end
      EOL: begin
        if (out_free) begin
          emit      = 1'b1;
          edge_step = 1'b1;
        end
      end
      FLUSH: begin
        if (x_end) begin
          if (out_free) begin
            emit      = 1'b1;
            edge_step = 1'b1;
          end
        end else if (x_cnt == '0) begin
          step_en = 1'b1;
        end else if (out_free) begin
          step_en = 1'b1;
          emit    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Line buffers shift on every accepted frame pixel; a sof pixel always lands at column 0
  assign lb_shift = in_acc && (in_sof || state != IDLE);
  assign lb_addr  = (in_acc && in_sof) ? '0 : AW'(clamp_idx(int'(x_cnt), IMG_W - 1));

  gauss_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW), .AW(AW)) u_lb1 (
    .clk  (clk),
    .en   (lb_shift),
    .addr (lb_addr),
    .din  (in_pixel),
    .dout (lb1_q)
  );

  gauss_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW), .AW(AW)) u_lb2 (
    .clk  (clk),
    .en   (lb_shift),
    .addr (lb_addr),
    .din  (lb1_q),
    .dout (lb2_q)
  );

  // Incoming column with top/bottom replication for the first and last output rows
  always_comb begin
    new_col[0] = (state == RUN && y_cnt == YW'(1)) ? lb1_q : lb2_q;
    new_col[1] = lb1_q;
    new_col[2] = (state == FLUSH) ? lb1_q : in_pixel;
  end

  // 3x3 window: left column replicates at column 0, right column at column IMG_W-1
  assign col_l = (!edge_step && x_cnt == XW'(1)) ? prev1 : prev2;
  assign col_r = edge_step ? prev1 : new_col;
  assign win   = {col_r, prev1, col_l};

  // Weighted 9-tap sum per channel
  always_comb begin
    sums = '0;
    for (int ch = 0; ch < CH; ch++)
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          sums[ch] = sums[ch] + SUM_W'(kernel_weight(c, r)) * SUM_W'(win[c][r][ch*DW +: DW]);
  end

`ifdef GAUSS_ROUND_EN
  logic [CH-1:0][SUM_W:0] rnd;
  logic [CH-1:0][DW:0]    quo;

  // Round half up, saturating at full scale
  always_comb begin
    rnd    = '0;
    quo    = '0;
    result = '0;
    for (int ch = 0; ch < CH; ch++) begin
      rnd[ch] = (SUM_W+1)'(sums[ch]) + (SUM_W+1)'(ROUND_HALF);
      quo[ch] = (DW+1)'(rnd[ch] >> KERNEL_SHIFT);
      result[ch*DW +: DW] = quo[ch][DW] ? {DW{1'b1}} : quo[ch][DW-1:0];
    end
  end
`else
  // Truncate the weighted sum
  always_comb begin
    result = '0;
    for (int ch = 0; ch < CH; ch++)
      result[ch*DW +: DW] = DW'(sums[ch] >> KERNEL_SHIFT);
  end
`endif

  // Window history shifts one column per step; pure datapath, qualified by the FSM
  always_ff @(posedge clk) begin
    if (step_en) begin
      prev2 <= prev1;
      prev1 <= new_col;
    end
  end

  // FSM and raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (in_acc && in_sof) begin
      state <= PRIME;
      x_cnt <= XW'(1);
      y_cnt <= '0;
    end else begin
      case (state)
        PRIME: begin
          if (in_acc) begin
            if (x_last) begin
              state <= RUN;
              x_cnt <= '0;
              y_cnt <= YW'(1);
            end else begin
              x_cnt <= x_cnt + XW'(1);
            end
          end
        end
        RUN: begin
          if (in_acc) begin
            if (x_last) state <= EOL;
            else        x_cnt <= x_cnt + XW'(1);
          end
        end
        EOL: begin
          if (out_free) begin
            x_cnt <= '0;
            if (y_last) begin
              state <= FLUSH;
            end else begin
              state <= RUN;
              y_cnt <= y_cnt + YW'(1);
            end
          end
        end
        FLUSH: begin
          if (x_end) begin
            if (out_free) begin
              state <= IDLE;
              x_cnt <= '0;
              y_cnt <= '0;
            end
          end else if (step_en) begin
            x_cnt <= x_cnt + XW'(1);
          end
        end
        IDLE:    ;
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: load on emit, hold while stalled, drop on drain or frame abort
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (sof_restart) begin
      out_valid <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_pixel <= result;
      out_sof   <= (state == RUN) && (x_cnt == XW'(1)) && (y_cnt == YW'(1));
      out_eol   <= edge_step;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
